// File: rtl/imem_line_responder.sv
// imem_line_responder: one-line instruction buffer that answers fetch requests
// and refills itself from a 16-bit physical memory port in 8 beats on a miss.
module imem_line_responder (
    input  logic         clk,
    input  logic         reset,
    input  logic         imem_action_stb,
    input  logic         imem_action_cyc,
    input  logic [15:0]  imem_address,
    output logic [127:0] imem_rdata,
    output logic         imem_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    input  logic [15:0]  pmem_rdata,
    input  logic         pmem_resp
);
    typedef enum logic [1:0] {IDLE, FILL, RESPOND} state_t;

    state_t         state, state_next;
    logic           valid;
    logic [11:0]    tag;
    logic [127:0]   line;
    logic [2:0]     beat;
    logic           req, same, hit, last_beat;

    assign req       = imem_action_stb && imem_action_cyc;
    assign same      = req && (imem_address[15:4] == tag);
    assign hit       = same && valid;
    assign last_beat = pmem_resp && (beat == 3'd7);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = req ? (hit ? RESPOND : FILL) : IDLE;
            FILL:    state_next = last_beat ? (same ? RESPOND : IDLE) : FILL;
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            valid <= 1'b0;
            tag   <= 12'd0;
            line  <= 128'd0;
            beat  <= 3'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && req && !hit) begin
                tag   <= imem_address[15:4];
                valid <= 1'b0;
                beat  <= 3'd0;
            end else if (state == FILL && pmem_resp) begin
                line[{beat, 4'b0000} +: 16] <= pmem_rdata;
                if (beat == 3'd7)
                    valid <= 1'b1;
                else
                    beat <= beat + 3'd1;
            end
        end
    end

    // Address and read strobe come straight from registers, so reset drops them at once
    assign pmem_address = {tag, beat, 1'b0};
    assign pmem_read    = (state == FILL);
    assign imem_resp    = (state == RESPOND);
    assign imem_rdata   = line;
endmodule

// File: doc/imem_line_responder.md
# imem_line_responder

Instruction-side memory responder for the LC-3b pipeline. It answers the fetch stage's strobe/cycle requests with a full 128-bit instruction line and a one-cycle `imem_resp` acknowledge. It holds one line in a buffer. On a miss it refills that buffer from a 16-bit physical memory port, one word per beat over 8 beats. It sits between the fetch stage and physical memory, with the fetch stage as initiator and this block as responder.

## Interface
- Parameters: none. Line is fixed at 8 × 16-bit words; `lc3b_word` and `lc3b_data` come from `lc3b_types`.
- Ports:
  - `clk`  in  1  sole clock; all state updates on the rising edge.
  - `reset`  in  1  asynchronous, active-high reset.
  - `imem_action_stb`  in  1  request strobe.
  - `imem_action_cyc`  in  1  bus cycle valid. A request is present when `stb && cyc`.
  - `imem_address`  in  16  byte address of the requested instruction; bits [15:4] select the line.
  - `imem_rdata`  out  128  line buffer contents; word i occupies [16i+15:16i].
  - `imem_resp`  out  1  acknowledge, high for exactly one cycle per served request.
  - `pmem_address`  out  16  beat address, {tag, beat[2:0], 1'b0}.
  - `pmem_read`  out  1  physical read request, held high for the whole of FILL.
  - `pmem_rdata`  in  16  physical read data, valid while `pmem_resp` is high.
  - `pmem_resp`  in  1  physical beat complete, one cycle per beat.

## Operation
- State: `valid` (1), `tag` (12), `line` (128), `beat` (3), FSM in {IDLE, FILL, RESPOND}.
- IDLE:
  - No request: stay in IDLE.
  - Hit (request present, `valid`, and `imem_address[15:4] == tag`): go to RESPOND.
  - Miss (request present, otherwise): `tag <= imem_address[15:4]`, `valid <= 0`, `beat <= 0`, go to FILL.
- FILL:
  - `pmem_read = 1`.
  - On `pmem_resp`: `line[16*beat +: 16] <= pmem_rdata`.
  - If `beat != 7`: `beat <= beat + 1`.
  - If `beat == 7`: `valid <= 1`. Go to RESPOND if a request is still present and `imem_address[15:4] == tag`; otherwise go to IDLE.
  - `beat` increments without wrap beyond 7, since FILL exits at 7.
- RESPOND: `imem_resp = 1` for this single cycle, `imem_rdata = line`, then go to IDLE unconditionally.
- `imem_rdata` is always driven from `line`. Word selection is the requester's job.
- `pmem_resp` outside FILL is ignored.
- Requester rule: `stb`, `cyc` and `imem_address` stay stable until `imem_resp`. If the request is dropped or changed mid-fill, the fill still completes and the line becomes valid, but no acknowledge is issued for the abandoned request. A changed address is evaluated afresh from IDLE.
- Reset values: state IDLE, `valid` 0, `tag` 0, `beat` 0, `line` 0. Outputs: `imem_resp` 0, `pmem_read` 0, `pmem_address` 0x0000, `imem_rdata` 0.
- Reset asserted mid-fill aborts the fill immediately. `pmem_read` falls asynchronously and the partial line is discarded (`valid` 0).

## Timing
- Hit latency: request seen in IDLE at edge N, `imem_resp` high in cycle N+1.
- Hit throughput: one line per 2 cycles (RESPOND → IDLE → RESPOND).
- Miss latency: `imem_resp` is high in the cycle after the edge that samples the 8th `pmem_resp`. With 1-cycle pmem, the request is at cycle 0, beats complete in cycles 1–8, and `imem_resp` is high in cycle 9.
- `pmem_address` changes only on a beat-advance edge or a miss edge.
- `imem_rdata` is stable throughout RESPOND.

## Test plan
- Reset: assert `reset` for 2 cycles with random inputs. Required: `imem_resp`=0, `pmem_read`=0, `pmem_address`=0, `imem_rdata`=0; the first request is serviced as a miss.
- Cold miss: request 0x1234; pmem returns 0xA000+i on beat i with 1-cycle latency. Required:
  - `pmem_address` steps 0x1230, 0x1232, …, 0x123E.
  - `imem_resp` is high for one cycle at cycle 9.
  - `imem_rdata` = {0xA007, …, 0xA000}.
- Hit: immediately request 0x123A. Required: `imem_resp` in the next cycle, `pmem_read` never rises, and `imem_rdata[95:80]` = 0xA005.
- Replacement: request 0x2000 (miss, refill with 0xB000+i), then 0x1230. Required: 0x1230 misses again with a full 8-beat refill from 0x1230.
- Abandoned request: drop `stb` after beat 3 of a miss to 0x4000. Required: all 8 beats complete and no `imem_resp`; a later request to 0x400E hits with a 1-cycle response and `imem_rdata[127:112]` = beat-7 data.
- Reset mid-fill: assert `reset` during beat 5. Required: `pmem_read` drops in the same cycle; after release, a request to the same line performs a full 8-beat refill.
